// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, result type and FSM states.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef logic [63:0] mdu_res_t;

    typedef enum logic [0:0] {StIdle, StRun} mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle. The pipeline drives the master side.
interface mdu_if;
    logic [3:0]  MDU_op;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    modport master (
        output MDU_op, start, A, B, req,
        input  busy, HI, LO, MDU_out
    );

    modport slave (
        input  MDU_op, start, A, B, req,
        output busy, HI, LO, MDU_out
    );
endinterface

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU. Produces the {HI,LO} value that will
// be committed when the multi-cycle operation completes. Ops that leave HI/LO
// untouched (divide by zero, non-arithmetic ops) pass hi_i/lo_i through.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by MDU_MADD_EN.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdu_res_t    prod_s;
    mdu_res_t    prod_u;
    mdu_res_t    acc;
    mdu_res_t    res;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Select the result for the decoded operation.
    always_comb begin
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u = {32'h0, a_i} * {32'h0, b_i};
        acc    = {hi_i, lo_i};
        quo_s  = 32'h0;
        rem_s  = 32'h0;
        res    = acc;
        case (op_i)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                if (b_i == 32'h0) begin
                    res = acc;
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    // Quotient overflows; pin to the architecturally defined value.
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    quo_s = $signed(a_i) / $signed(b_i);
                    rem_s = $signed(a_i) % $signed(b_i);
                    res   = {rem_s, quo_s};
                end
            end
            MDU_DIVU: begin
                if (b_i == 32'h0) begin
                    res = acc;
                end else begin
                    res = {a_i % b_i, a_i / b_i};
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  res = acc + prod_s;
            MDU_MADDU: res = acc + prod_u;
            MDU_MSUB:  res = acc - prod_s;
            MDU_MSUBU: res = acc - prod_u;
`endif
            default:   res = acc;
        endcase
    end

    assign hi_o = res[63:32];
    assign lo_o = res[31:0];

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage. Owns HI/LO, runs mult/div with fixed
// latency, serves mf/mt moves and reports busy to the stall logic.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d;
    logic [31:0] lo_n_q, lo_n_d;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        is_md_op;
    logic        is_div;

    mdu_calc u_calc (
        .a_i  (bus.A),
        .b_i  (bus.B),
        .op_i (bus.MDU_op),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    // Decode which ops start a multi-cycle operation and which latency they use.
    always_comb begin
        is_div   = (bus.MDU_op == MDU_DIV) || (bus.MDU_op == MDU_DIVU);
        is_md_op = (bus.MDU_op >= MDU_MULT) && (bus.MDU_op <= MDU_DIVU);
`ifdef MDU_MADD_EN
        if (bus.MDU_op >= MDU_MADD && bus.MDU_op <= MDU_MSUBU) begin
            is_md_op = 1'b1;
        end
`endif
    end

    // Next-state: accept/countdown/commit, plus mt moves while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.req) begin
                    if (bus.start && is_md_op) begin
                        hi_n_d  = calc_hi;
                        lo_n_d  = calc_lo;
                        cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state_d = StRun;
                    end else if (bus.MDU_op == MDU_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.MDU_op == MDU_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            StRun: begin
                // req does not cancel: the running op belongs to a committed instruction.
                if (cnt_q == 4'd1) begin
                    hi_d    = hi_n_q;
                    lo_d    = lo_n_q;
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            hi_n_q  <= 32'h0;
            lo_n_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
        end
    end

    // Outputs: status, architectural registers and the mf read mux.
    always_comb begin
        bus.busy    = (state_q == StRun);
        bus.HI      = hi_q;
        bus.LO      = lo_q;
        bus.MDU_out = 32'h0;
        if (bus.MDU_op == MDU_MFHI) begin
            bus.MDU_out = hi_q;
        end else if (bus.MDU_op == MDU_MFLO) begin
            bus.MDU_out = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The stall logic must never present start while busy.
    always @(posedge clk) begin
        if (!reset && bus.start && bus.busy) begin
            errors++;
            $error("FAIL start_while_busy: start=%0b busy=%0b required no overlap",
                   bus.start, bus.busy);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.MDU_op = MDU_NONE;
        bus.start  = 1'b0;
        bus.req    = 1'b0;
        bus.A      = 32'h0;
        bus.B      = 32'h0;
    endtask

    // Issue one multi-cycle op, check busy for n cycles, then the committed HI/LO
    // and the mf read path.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        old_hi     = bus.HI;
        bus.MDU_op = op;
        bus.start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        step();
        idle();
        check({tag, "_hi_held"}, bus.HI, old_hi);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            step();
        end
        check({tag, "_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_hi"}, bus.HI, exp_hi);
        check({tag, "_lo"}, bus.LO, exp_lo);
        bus.MDU_op = MDU_MFHI;
        #1;
        check({tag, "_mfhi"}, bus.MDU_out, exp_hi);
        bus.MDU_op = MDU_MFLO;
        #1;
        check({tag, "_mflo"}, bus.MDU_out, exp_lo);
        idle();
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic rq);
        bus.MDU_op = op;
        bus.A      = a;
        bus.req    = rq;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.HI, 32'h0);
        check("rst_lo", bus.LO, 32'h0);
        check("rst_out", bus.MDU_out, 32'h0);

        run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1);
        run_op("divu", MDU_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        // Divide by zero keeps previous HI/LO.
        mt(MDU_MTHI, 32'h11, 1'b0);
        check("mthi", bus.HI, 32'h11);
        mt(MDU_MTLO, 32'h22, 1'b0);
        check("mtlo", bus.LO, 32'h22);
        run_op("div0", MDU_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);

        // req blocks start acceptance and mt writes.
        bus.MDU_op = MDU_MULT;
        bus.start  = 1'b1;
        bus.req    = 1'b1;
        bus.A      = 32'd2;
        bus.B      = 32'd3;
        step();
        idle();
        check("req_start_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("req_start_hi", bus.HI, 32'h11);
        check("req_start_lo", bus.LO, 32'h22);
        mt(MDU_MTLO, 32'h55, 1'b1);
        check("req_mtlo", bus.LO, 32'h22);
        mt(MDU_MTHI, 32'h66, 1'b1);
        check("req_mthi", bus.HI, 32'h11);

        // req during a running mult does not cancel it.
        bus.MDU_op = MDU_MULT;
        bus.start  = 1'b1;
        bus.A      = 32'd4;
        bus.B      = 32'd5;
        step();
        idle();
        step();
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        check("req_run_busy", 32'(bus.busy), 32'd1);
        step();
        step();
        check("req_run_busy2", 32'(bus.busy), 32'd1);
        step();
        check("req_run_done", 32'(bus.busy), 32'd0);
        check("req_run_hi", bus.HI, 32'h0);
        check("req_run_lo", bus.LO, 32'h14);

        // Reset mid-div aborts without a later commit.
        bus.MDU_op = MDU_DIVU;
        bus.start  = 1'b1;
        bus.A      = 32'd100;
        bus.B      = 32'd7;
        step();
        idle();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_hi", bus.HI, 32'h0);
        check("rst_mid_lo", bus.LO, 32'h0);
        for (int i = 0; i < 12; i++) step();
        check("rst_mid_late_hi", bus.HI, 32'h0);
        check("rst_mid_late_lo", bus.LO, 32'h0);

        // Accumulate op: present only with MDU_MADD_EN.
        mt(MDU_MTLO, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
        run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        bus.MDU_op = MDU_MADDU;
        bus.start  = 1'b1;
        bus.A      = 32'd1;
        bus.B      = 32'd1;
        step();
        idle();
        check("maddu_off_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("maddu_off_hi", bus.HI, 32'h0);
        check("maddu_off_lo", bus.LO, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
